// File: rtl/ahbl_grant_sched_pkg.sv
// Shared encodings and helpers for the AHB-Lite grant scheduler.
// HTRANS values and the reset round-robin pointer live here.
package ahbl_grant_sched_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_t;

   typedef enum logic [1:0] {
      SRC_NONE,
      SRC_STALL,
      SRC_LOCK,
      SRC_PICK
   } gnt_src_t;

   // One-hot pointer at the top port, so a scan from here starts at port 0.
   function automatic logic [31:0] onehot_top(input int n);
      return 32'd1 << (n - 1);
   endfunction

endpackage

// File: rtl/ahbl_grant_sched_if.sv
// Request/grant bundle between the AHB-Lite masters and the scheduler.
// The scheduler sits on the slave modport.
interface ahbl_grant_sched_if #(
   parameter int N_PORTS = 2
);
   logic [N_PORTS-1:0] req;
   logic [N_PORTS-1:0] mastlock;
   logic               hready;
   logic               rr_en;
   logic [N_PORTS-1:0] gnt_a;
   logic [N_PORTS-1:0] gnt_d;
   logic               lock_active;
   logic               quota_hit;

   modport master (
      output req, mastlock, hready, rr_en,
      input  gnt_a, gnt_d, lock_active, quota_hit
   );

   modport slave (
      input  req, mastlock, hready, rr_en,
      output gnt_a, gnt_d, lock_active, quota_hit
   );
endinterface

// File: rtl/ahbl_rr_pick.sv
// Combinational cyclic one-hot picker.
// Scans req & ~mask starting just after the one-hot start pointer.
module ahbl_rr_pick #(
   parameter int N_PORTS = 2
) (
   input  logic [N_PORTS-1:0] req,
   input  logic [N_PORTS-1:0] mask,
   input  logic [N_PORTS-1:0] start,
   output logic [N_PORTS-1:0] gnt
);

   logic [N_PORTS-1:0] elig;
   int                 base;
   int                 k;
   logic               found;

   assign elig = req & ~mask;

   always_comb begin
      gnt   = '0;
      base  = 0;
      k     = 0;
      found = 1'b0;
      for (int i = 0; i < N_PORTS; i++) begin
         if (start[i]) base = i;
      end
      for (int i = 1; i <= N_PORTS; i++) begin
         k = (base + i) % N_PORTS;
         if (!found && elig[k]) begin
            gnt[k] = 1'b1;
            found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ahbl_grant_sched.sv
// Address/data-phase grant scheduler for the N:1 AHB-Lite arbiter.
// Priority or round-robin pick with lock, stall hold and starvation quota.
module ahbl_grant_sched
   import ahbl_grant_sched_pkg::*;
#(
   parameter int N_PORTS = 2,
   parameter int QUOTA   = 8,
   parameter int W_QUOTA = 4
) (
   input logic              clk,
   input logic              rst_n,
   ahbl_grant_sched_if.slave bus
);

   localparam logic [31:0]        RST_PTR_W = onehot_top(N_PORTS);
   localparam logic [N_PORTS-1:0] RST_PTR   = RST_PTR_W[N_PORTS-1:0];
   localparam logic [N_PORTS-1:0] NONE      = '0;
   localparam logic [W_QUOTA-1:0] QUOTA_W   = W_QUOTA'(QUOTA);

   logic [N_PORTS-1:0] req;
   logic [N_PORTS-1:0] lock;
   logic [N_PORTS-1:0] last;
   logic [N_PORTS-1:0] lock_owner;
   logic [N_PORTS-1:0] stall_gnt;
   logic               stall_valid;
   logic               lock_active;
   logic               quota_hit;
   logic [W_QUOTA-1:0] quota_cnt;
   logic [N_PORTS-1:0] gnt_d;

   logic [N_PORTS-1:0] rr_gnt;
   logic [N_PORTS-1:0] pr_gnt;
   logic [N_PORTS-1:0] prm_gnt;
   logic [N_PORTS-1:0] pr_mask;
   logic [N_PORTS-1:0] gnt_a;
   logic               quota_mask;
   logic               hit_now;
   logic               others;
   gnt_src_t           src;

   assign req  = bus.req;
   assign lock = bus.mastlock;

   assign quota_mask = (QUOTA != 0) && (quota_cnt == QUOTA_W)
                       && |(req & ~last);
   assign pr_mask    = quota_mask ? last : NONE;

   ahbl_rr_pick #(.N_PORTS(N_PORTS)) u_rr (
      .req   (req),
      .mask  (NONE),
      .start (last),
      .gnt   (rr_gnt)
   );

   ahbl_rr_pick #(.N_PORTS(N_PORTS)) u_pr (
      .req   (req),
      .mask  (NONE),
      .start (RST_PTR),
      .gnt   (pr_gnt)
   );

   ahbl_rr_pick #(.N_PORTS(N_PORTS)) u_prm (
      .req   (req),
      .mask  (pr_mask),
      .start (RST_PTR),
      .gnt   (prm_gnt)
   );

   always_comb begin
      src   = SRC_NONE;
      gnt_a = NONE;
      if (stall_valid && |(req & stall_gnt))
         src = SRC_STALL;
      else if (lock_active && |(req & lock_owner))
         src = SRC_LOCK;
      else if (|req)
         src = SRC_PICK;
      unique case (src)
         SRC_STALL: gnt_a = stall_gnt;
         SRC_LOCK:  gnt_a = lock_owner;
         SRC_PICK:  gnt_a = bus.rr_en ? rr_gnt : prm_gnt;
         default:   gnt_a = NONE;
      endcase
   end

   // Quota only counts as a hit when masking actually moved the pick.
   assign hit_now = (src == SRC_PICK) && !bus.rr_en
                    && quota_mask && (pr_gnt != prm_gnt);
   assign others  = |(req & ~gnt_a);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         gnt_d       <= NONE;
         last        <= RST_PTR;
         lock_active <= 1'b0;
         lock_owner  <= NONE;
         quota_cnt   <= '0;
         quota_hit   <= 1'b0;
         stall_valid <= 1'b0;
         stall_gnt   <= NONE;
      end else if (bus.hready) begin
         gnt_d       <= gnt_a;
         stall_valid <= 1'b0;
         quota_hit   <= hit_now;
         if (|gnt_a)
            last <= gnt_a;
         if (gnt_a == NONE)
            quota_cnt <= '0;
         else if (gnt_a != last)
            quota_cnt <= W_QUOTA'(1);
         else if (others)
            quota_cnt <= (quota_cnt == '1) ? quota_cnt
                                           : quota_cnt + 1'b1;
         else
            quota_cnt <= '0;
         if (|(gnt_a & lock)) begin
            lock_active <= 1'b1;
            lock_owner  <= gnt_a;
         end else if (lock_active
                      && (gnt_a == lock_owner
                          || !(|(req & lock_owner)))) begin
            lock_active <= 1'b0;
         end
      end else begin
         quota_hit <= 1'b0;
         if (|gnt_a) begin
            stall_valid <= 1'b1;
            stall_gnt   <= gnt_a;
         end
      end
   end

   assign bus.gnt_a       = gnt_a;
   assign bus.gnt_d       = gnt_d;
   assign bus.lock_active = lock_active;
   assign bus.quota_hit   = quota_hit;

endmodule

// File: doc/ahbl_grant_sched.md
Name: ahbl_grant_sched

Overview:
- Address-phase grant scheduler for the N:1 AHB-Lite arbiter in the bus fabric; it replaces the fixed strict-priority one-hot picker.
- Produces a one-hot address-phase grant (gnt_a) and a data-phase grant (gnt_d) that drive the arbiter's muxes.
- Supports strict-priority or round-robin selection, HMASTLOCK sequences, and a starvation quota in priority mode.
- Grant state advances only when the shared slave accepts an address phase (hready high).

Parameters:
- N_PORTS, 2: number of requesting masters; port 0 is highest priority in priority mode.
- QUOTA, 8: maximum consecutive grants to one port while another port requests, priority mode only; 0 disables the quota.
- W_QUOTA, 4: quota counter width; must satisfy QUOTA < 2^W_QUOTA.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low
- req  in  N_PORTS  per-port address-phase request (HTRANS[1] of that port's actual signals)
- mastlock  in  N_PORTS  per-port HMASTLOCK qualifying req
- hready  in  1  slave-side HREADY; high means the current address phase is accepted this cycle
- rr_en  in  1  1 = round-robin, 0 = strict priority; sampled every cycle
- gnt_a  out  N_PORTS  one-hot or zero address-phase grant (combinational from state and inputs)
- gnt_d  out  N_PORTS  registered data-phase grant
- lock_active  out  1  a locked sequence owns the bus
- quota_hit  out  1  registered one-cycle pulse when the quota forced a grant away from the holder

Behaviour:
- Reset (rst_n low at a clk edge) applies, including mid-transfer:
  - gnt_d = 0, lock_active = 0, quota_hit = 0, quota_cnt = 0, stall_valid = 0.
  - last pointer = port N_PORTS-1, so the first round-robin grant goes to the lowest requesting index.
- State registers: last (one-hot), lock_owner/lock_active, quota_cnt, stall_gnt/stall_valid, gnt_d, quota_hit.
- gnt_a selection, first matching rule wins:
  1. stall_valid && (req & stall_gnt) != 0 -> stall_gnt. A stalled address phase is never re-arbitrated.
  2. lock_active && req[lock_owner] -> lock_owner. Other requesters are blocked.
  3. rr_en = 1 -> first requesting port scanning cyclically from last+1; wraps from N_PORTS-1 to 0.
  4. rr_en = 0 -> lowest-index requesting port. If QUOTA != 0, quota_cnt == QUOTA, and another port also requests, mask the port in last for this pick only.
  5. No req -> gnt_a = 0.
- Cycle update when hready = 1:
  - gnt_d <= gnt_a; stall_valid <= 0.
  - If gnt_a != 0: last <= gnt_a.
  - quota_cnt:
    - gnt_a == last && another port requesting -> saturating increment.
    - gnt_a != last -> 1.
    - No other requester -> 0.
  - quota_hit <= 1 only when rule 4 masking changed the pick; otherwise 0.
  - Lock:
    - Granted port with mastlock = 1 -> lock_active <= 1, lock_owner <= that port.
    - Granted owner with mastlock = 0, or owner's req = 0 -> lock_active <= 0.
- Cycle update when hready = 0:
  - gnt_d, last, quota_cnt and lock hold.
  - If gnt_a != 0: stall_valid <= 1, stall_gnt <= gnt_a.
  - quota_hit <= 0.
- Simultaneous events:
  - Lock release and a new request in the same accepted cycle: the release takes effect next cycle; the new pick uses rules 3/4.
  - rr_en toggling mid-stream affects the next pick only; a stalled grant is kept.
- Invariant: gnt_a and gnt_d are always one-hot or zero, and gnt_a is always a subset of req.

Decomposition:
- Shared header (included like hazard3_config.vh) holds the HTRANS encodings and a localparam for the reset pointer.
- One sub-module: ahbl_rr_pick, a combinational cyclic one-hot picker taking req, mask and start pointer.
- Priority mode reuses ahbl_rr_pick with start pointer fixed to N_PORTS-1.

Test Plan:
- Priority with quota: N_PORTS = 2, QUOTA = 2, rr_en = 0, req = 2'b11, hready = 1 -> gnt_a sequence 01, 01, 10, 01, 01, 10; quota_hit pulses on each 10.
- Round-robin: rr_en = 1, N_PORTS = 3, req = 3'b111 steady -> gnt_a 001, 010, 100, 001, ...; gnt_d equals the previous cycle's gnt_a.
- Stall hold: port 1 granted, hready = 0 for 3 cycles while port 0 raises req -> gnt_a stays 10; next cycle with hready = 1, gnt_d = 10.
- Lock: port 1 req with mastlock = 1 for 2 accepted beats, then mastlock = 0, while port 0 requests throughout -> gnt_a = 10 for 3 beats, then 01; lock_active high for exactly 2 cycles.
- Reset mid-stall: rst_n low for 1 edge during hready = 0 -> next cycle gnt_d = 0, lock_active = 0; with rr_en = 1, req = 11 the first grant is 01.
- Idle: req = 0 with hready = 1 -> gnt_a = 0, gnt_d = 0 next cycle, quota_cnt = 0.
